// File: rtl/vga_pkg.sv
// Shared definitions for the VGA tile generator: default 640x480@60 timing,
// the 8-bit-per-channel colour struct and the power-up palette.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int DEF_PAL_N = 9;

  localparam rgb_t DEF_PALETTE [DEF_PAL_N] = '{
    24'hFFFFFF, 24'h10AAFF, 24'h10FFFF,
    24'h2050AF, 24'hAA00FF, 24'h00FFFF,
    24'h10FA6F, 24'h6055AF, 24'hA0534F
  };

  // Grids larger than the default palette power up black beyond entry 8.
  function automatic rgb_t def_palette_entry(input int idx);
    if (idx >= 0 && idx < DEF_PAL_N)
      return DEF_PALETTE[idx];
    return '0;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Raster position counters plus registered hsync/vsync/de/pixel-coordinate/sof,
// all one cycle behind the h/v state exported to the tile logic.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int SYNC_POL = 0
) (
  input  logic        rst,
  input  logic        clk_25Mhz,
  output logic [15:0] h_o,
  output logic [15:0] v_o,
  output logic        h_last_o,
  output logic        v_last_o,
  output logic        active_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic [15:0] pix_x_o,
  output logic [15:0] pix_y_o,
  output logic        sof_o
);

  localparam logic [15:0] H_TOTAL  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] V_TOTAL  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [15:0] H_ACT_L  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT_L  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        POL      = (SYNC_POL != 0);

  logic [15:0] h_q, h_d, v_q, v_d;
  logic [15:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        de_q, de_d, sof_q, sof_d;
  logic        h_last, v_last, active;

  always_comb begin
    h_last  = (h_q == H_TOTAL - 16'd1);
    v_last  = (v_q == V_TOTAL - 16'd1);
    active  = (h_q < H_ACT_L) && (v_q < V_ACT_L);
    h_d     = h_last ? 16'd0 : h_q + 16'd1;
    v_d     = v_q;
    if (h_last)
      v_d = v_last ? 16'd0 : v_q + 16'd1;
    hsync_d = ((h_q >= HS_START) && (h_q < HS_END)) ? POL : ~POL;
    vsync_d = ((v_q >= VS_START) && (v_q < VS_END)) ? POL : ~POL;
    de_d    = active;
    pix_x_d = active ? h_q : 16'd0;
    pix_y_d = active ? v_q : 16'd0;
    sof_d   = (h_q == 16'd0) && (v_q == 16'd0);
  end

  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= ~POL;
      vsync_q <= ~POL;
      de_q    <= 1'b0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      sof_q   <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      sof_q   <= sof_d;
    end
  end

  assign h_o      = h_q;
  assign v_o      = v_q;
  assign h_last_o = h_last;
  assign v_last_o = v_last;
  assign active_o = active;
  assign hsync_o  = hsync_q;
  assign vsync_o  = vsync_q;
  assign de_o     = de_q;
  assign pix_x_o  = pix_x_q;
  assign pix_y_o  = pix_y_q;
  assign sof_o    = sof_q;

endmodule

// File: rtl/vga_tile_gen.sv
// VGA tile-grid generator with a double-buffered palette swapped at vertical blank.
// Optional per-tile blinking is enabled by defining VGA_TILE_BLINK_EN.
module vga_tile_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int H_FP         = VGA_H_FP,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_BP         = VGA_H_BP,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int V_FP         = VGA_V_FP,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_BP         = VGA_V_BP,
  parameter int SYNC_POL     = 0,
  parameter int TILE_COLS    = 3,
  parameter int TILE_ROWS    = 3,
  parameter int COLOR_W      = 8,
  parameter int BLINK_FRAMES = 30,
  localparam int N           = TILE_COLS * TILE_ROWS,
  localparam int IDX_W       = (N > 1) ? $clog2(N) : 1,
  localparam int PIX_W       = 3 * COLOR_W
) (
  input  logic               rst,
  input  logic               clk_25Mhz,
  input  logic               pal_we,
  input  logic [IDX_W-1:0]   pal_idx,
  input  logic [PIX_W-1:0]   pal_rgb,
  input  logic [PIX_W-1:0]   bg_rgb,
`ifdef VGA_TILE_BLINK_EN
  input  logic [N-1:0]       blink_mask,
`endif
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [15:0]        pix_x,
  output logic [15:0]        pix_y,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               sof
);

  if (TILE_COLS < 1 || TILE_ROWS < 1 || TILE_COLS > H_ACTIVE || TILE_ROWS > V_ACTIVE) begin : g_bad_grid
    $error("vga_tile_gen: tile grid must be non-empty and fit inside the active area");
  end

  localparam logic [15:0] H_ACT_L  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT_L  = 16'(V_ACTIVE);
  localparam logic [15:0] TILE_W   = 16'(H_ACTIVE / TILE_COLS);
  localparam logic [15:0] TILE_H   = 16'(V_ACTIVE / TILE_ROWS);
  localparam logic [15:0] LAST_COL = 16'(TILE_COLS - 1);
  localparam logic [15:0] LAST_ROW = 16'(TILE_ROWS - 1);
  localparam logic [15:0] COLS_L   = 16'(TILE_COLS);

  // Keep the top COLOR_W bits of each 8-bit channel (zero-extend if wider).
  function automatic logic [PIX_W-1:0] to_px(input rgb_t c);
    logic [COLOR_W+7:0] er, eg, eb;
    er = {c.r, {COLOR_W{1'b0}}};
    eg = {c.g, {COLOR_W{1'b0}}};
    eb = {c.b, {COLOR_W{1'b0}}};
    return {er[COLOR_W+7 -: COLOR_W], eg[COLOR_W+7 -: COLOR_W], eb[COLOR_W+7 -: COLOR_W]};
  endfunction

  logic [15:0] h, v;
  logic        h_last, v_last, active;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_sync (
    .rst       (rst),
    .clk_25Mhz (clk_25Mhz),
    .h_o       (h),
    .v_o       (v),
    .h_last_o  (h_last),
    .v_last_o  (v_last),
    .active_o  (active),
    .hsync_o   (hsync),
    .vsync_o   (vsync),
    .de_o      (de),
    .pix_x_o   (pix_x),
    .pix_y_o   (pix_y),
    .sof_o     (sof)
  );

  // Tile column/row track the current h/v; the last tile absorbs the remainder.
  logic [15:0] col_q, col_d, xc_q, xc_d, row_q, row_d, yc_q, yc_d;

  always_comb begin
    col_d = col_q;
    xc_d  = xc_q;
    row_d = row_q;
    yc_d  = yc_q;
    if (h_last) begin
      col_d = '0;
      xc_d  = '0;
      if (v_last) begin
        row_d = '0;
        yc_d  = '0;
      end else if (v < V_ACT_L && row_q != LAST_ROW) begin
        if (yc_q == TILE_H - 16'd1) begin
          row_d = row_q + 16'd1;
          yc_d  = '0;
        end else begin
          yc_d  = yc_q + 16'd1;
        end
      end
    end else if (h < H_ACT_L && col_q != LAST_COL) begin
      if (xc_q == TILE_W - 16'd1) begin
        col_d = col_q + 16'd1;
        xc_d  = '0;
      end else begin
        xc_d  = xc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      xc_q  <= '0;
      row_q <= '0;
      yc_q  <= '0;
    end else begin
      col_q <= col_d;
      xc_q  <= xc_d;
      row_q <= row_d;
      yc_q  <= yc_d;
    end
  end

  logic             copy;
  logic [PIX_W-1:0] shadow_q [N];
  logic [PIX_W-1:0] active_q [N];

  assign copy = (h == 16'd0) && (v == V_ACT_L);

  // Copy reads the old shadow, so a write in the swap cycle waits a frame.
  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= to_px(def_palette_entry(i));
        active_q[i] <= to_px(def_palette_entry(i));
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (copy)
          active_q[i] <= shadow_q[i];
        if (pal_we && pal_idx == IDX_W'(i))
          shadow_q[i] <= pal_rgb;
      end
    end
  end

  logic [15:0]      tile_lin;
  logic [PIX_W-1:0] tile_px;
  logic             tile_blink;
  logic             blink_on;

  assign tile_lin = row_q * COLS_L + col_q;

  always_comb begin
    tile_px    = '0;
    tile_blink = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (tile_lin == 16'(i)) begin
        tile_px = active_q[i];
`ifdef VGA_TILE_BLINK_EN
        tile_blink = blink_mask[i];
`endif
      end
    end
  end

`ifdef VGA_TILE_BLINK_EN
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

  logic [15:0] frame_q, frame_d;
  logic        phase_q, phase_d;

  always_comb begin
    frame_d = frame_q;
    phase_d = phase_q;
    if (copy) begin
      if (frame_q >= BLINK_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      phase_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      phase_q <= phase_d;
    end
  end

  assign blink_on = phase_q & tile_blink;
`else
  assign blink_on = 1'b0 & tile_blink;
`endif

  logic [PIX_W-1:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = '0;
    if (active)
      rgb_d = blink_on ? bg_rgb : tile_px;
  end

  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst)
      rgb_q <= '0;
    else
      rgb_q <= rgb_d;
  end

  assign red   = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign green = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue  = rgb_q[COLOR_W-1 -: COLOR_W];

endmodule

// File: doc/vga_tile_gen.md
VGA_TILE_GEN -- requirements
Module: vga_tile_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal front porch/sync/back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical front porch/sync/back porch in lines.
REQ-005 SHALL have parameter SYNC_POL, default 0, asserted level of hsync/vsync.
REQ-006 SHALL have parameters TILE_COLS/TILE_ROWS, defaults 3/3, tile grid size; N = TILE_COLS*TILE_ROWS.
REQ-007 SHALL have parameter COLOR_W, default 8, bits per colour channel.
REQ-008 SHALL have parameter BLINK_FRAMES, default 30, frames per blink phase.
REQ-009 SHALL have ports, in order: reset rst, asynchronous, active-high; clock clk_25Mhz.
REQ-010 SHALL have: pal_we in 1, palette write strobe; pal_idx in clog2(N), entry index; pal_rgb in 3*COLOR_W, {R,G,B} write data; bg_rgb in 3*COLOR_W, background/blink colour.
REQ-011 SHALL have: blink_mask in N, per-tile blink enable (only with VGA_TILE_BLINK_EN).
REQ-012 SHALL have outputs: hsync 1; vsync 1; de 1, active video; pix_x 16; pix_y 16; red/green/blue COLOR_W each; sof 1, first-pixel-of-frame pulse.

Function
REQ-013 SHALL count h 0..H_TOTAL-1 (H_TOTAL = sum of H params), wrapping to 0; v increments on h wrap, wrapping after V_TOTAL-1.
REQ-014 SHALL order each line/frame as active, front porch, sync, back porch.
REQ-015 SHALL drive hsync = SYNC_POL while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else !SYNC_POL; vsync likewise on v.
REQ-016 SHALL assert de when h<H_ACTIVE and v<V_ACTIVE; pix_x/pix_y = h/v while de, else 0.
REQ-017 SHALL register all outputs; every output SHALL reflect counter state with exactly 1 cycle latency, mutually aligned.
REQ-018 SHALL select tile column/row via boundary sub-counters (no divider); TILE_W = H_ACTIVE/TILE_COLS, TILE_H = V_ACTIVE/TILE_ROWS; remainder pixels/lines belong to the last column/row.
REQ-019 SHALL output palette_active[row*TILE_COLS+col] when de=1; rgb = 0 when de=0.
REQ-020 SHALL write pal_rgb to shadow entry pal_idx on pal_we; pal_idx >= N SHALL be ignored.
REQ-021 SHALL copy shadow to active palette in the cycle h=0, v=V_ACTIVE (start of vertical blank); a write in that same cycle SHALL land in shadow only and appear the following frame.
REQ-022 SHALL pulse sof for one cycle, aligned with the output pixel (0,0).

Reset
REQ-023 SHALL asynchronously on rst set h=v=0, tile counters 0, hsync=vsync=!SYNC_POL, de=0, pix_x=pix_y=0, rgb=0, sof=0, blink state 0.
REQ-024 SHALL reset both shadow and active palettes to the package default palette.
REQ-025 SHALL, after reset release mid-frame, restart at (0,0); sof SHALL be high after the first clock edge.

Configuration
REQ-026 SHALL, with VGA_TILE_BLINK_EN defined, count completed frames (at vertical blank start), toggle blink phase every BLINK_FRAMES frames, and output bg_rgb for active tiles whose blink_mask bit is 1 while phase=1.
REQ-027 SHALL, without VGA_TILE_BLINK_EN, omit blink_mask, the frame counter, and the phase logic; tiles are always drawn from the palette.

Structure
REQ-028 SHALL place in package vga_pkg: default 640x480@60 timing constants, rgb_t struct typedef, default 9-entry palette constant (FFFFFF,10AAFF,10FFFF,2050AF,AA00FF,00FFFF,10FA6F,6055AF,A0534F).
REQ-029 SHALL instantiate sub-module vga_sync_counter for h/v counting, sync and de generation.
REQ-030 SHALL raise an elaboration error if TILE_COLS>H_ACTIVE or TILE_ROWS>V_ACTIVE.

Verification
REQ-031 Reset release, run 420000 cycles -> hsync low 96 cycles/line from h=656; vsync low lines 490-491; 307200 de cycles and one sof per frame.
REQ-032 Default palette -> pixel (0,0)=FFFFFF; (213,0)=10AAFF; (426,0)=10FFFF (last column 214 wide); (639,479)=A0534F; blanking rgb=000000.
REQ-033 Write idx 4 = 123456 at y=100 -> (320,240) unchanged this frame, =123456 next frame.
REQ-034 Write idx 9 = 000000 -> no palette change in any frame.
REQ-035 Assert rst at h=300, v=200 -> outputs at reset values immediately; after release, sof high after first edge, pix (0,0).
REQ-036 With VGA_TILE_BLINK_EN, BLINK_FRAMES=2, blink_mask=1 -> tile 0 shows palette in frames 0-1, bg_rgb in frames 2-3, palette in 4-5.
